booth_mult_ctrl: RTL

- Sequencing controller for the 8-bit adder/subtractor (eightbitaddsub) that performs signed 8x8 radix-2 Booth multiplication.
- One add, subtract or no-op plus one arithmetic right shift per clock, over 8 iterations, giving a 16-bit two's-complement product.
- First multi-cycle client of the add/sub datapath. Uses the add/sub overflow flag to get the shift sign bit right.

---
 rtl/booth_mult_ctrl_pkg.sv | 31 +++
 rtl/booth_mult_ctrl_if.sv | 34 +++
 rtl/booth_mult_ctrl_addsub.sv | 21 ++
 rtl/booth_mult_ctrl.sv | 122 ++++++++++++
 4 files changed

// File: rtl/booth_mult_ctrl_pkg.sv
// rtl/booth_mult_ctrl_pkg.sv - shared types and constants for the Booth multiply controller
package booth_pkg;

  localparam int WIDTH = 8;
  localparam int ITER  = 8;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_e;

  typedef enum logic [1:0] {
    OP_NOP,
    OP_ADD,
    OP_SUB
  } booth_op_e;

  localparam logic MODE_ADD = 1'b1;
  localparam logic MODE_SUB = 1'b0;

  // Radix-2 Booth recoding of the current multiplier bit pair {Q[0], Q_1}.
  function automatic booth_op_e booth_decode(input logic q0, input logic q_1);
    case ({q0, q_1})
      2'b01:   return OP_ADD;
      2'b10:   return OP_SUB;
      default: return OP_NOP;
    endcase
  endfunction

endpackage

// File: rtl/booth_mult_ctrl_if.sv
// rtl/booth_mult_ctrl_if.sv - request/result bundle of the Booth multiplier (op_count under BOOTH_OPCNT_EN)
interface booth_mult_ctrl_if;

  logic        start;
  logic [7:0]  multiplicand;
  logic [7:0]  multiplier;
  logic        busy;
  logic        done;
  logic [15:0] product;
`ifdef BOOTH_OPCNT_EN
  logic [3:0]  op_count;
`endif

`ifdef BOOTH_OPCNT_EN
  modport master (
    output start, multiplicand, multiplier,
    input  busy, done, product, op_count
  );
  modport slave (
    input  start, multiplicand, multiplier,
    output busy, done, product, op_count
  );
`else
  modport master (
    output start, multiplicand, multiplier,
    input  busy, done, product
  );
  modport slave (
    input  start, multiplicand, multiplier,
    output busy, done, product
  );
`endif

endinterface

// File: rtl/booth_mult_ctrl_addsub.sv
// rtl/booth_mult_ctrl_addsub.sv - 8-bit adder/subtractor (mode 1 = add, mode 0 = data0 - data1)
module eightbitaddsub (
  input  logic [7:0] data0_i,
  input  logic [7:0] data1_i,
  input  logic       mode_i,
  output logic [7:0] sum_o,
  output logic       carry_out_o,
  output logic       overflow_o
);

  logic [7:0] operand_b;
  logic [8:0] full_sum;

  // Subtraction as data0 + ~data1 + 1.
  assign operand_b   = mode_i ? data1_i : ~data1_i;
  assign full_sum    = {1'b0, data0_i} + {1'b0, operand_b} + {8'd0, ~mode_i};
  assign sum_o       = full_sum[7:0];
  assign carry_out_o = full_sum[8];
  assign overflow_o  = (data0_i[7] == operand_b[7]) && (sum_o[7] != data0_i[7]);

endmodule

// File: rtl/booth_mult_ctrl.sv
// rtl/booth_mult_ctrl.sv - signed 8x8 radix-2 Booth multiply sequencer over eightbitaddsub
// Optional op_count output enabled by BOOTH_OPCNT_EN.
module booth_mult_ctrl #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 3
) (
  input  logic           clk,
  input  logic           rst,
  booth_mult_ctrl_if.slave bus
);

  import booth_pkg::*;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(ITER - 1);

  state_e               state_q;
  logic [WIDTH-1:0]     a_q, q_q, m_q;
  logic                 q1_q;
  logic [CNT_W-1:0]     count_q;
  logic                 busy_q, done_q;
  logic [2*WIDTH-1:0]   product_q;

  booth_op_e            op;
  logic                 alu_mode;
  logic [WIDTH-1:0]     alu_sum;
  logic                 alu_ovf;
  logic                 alu_cout_unused;
  logic [WIDTH-1:0]     r;
  logic                 sgn;
  logic [WIDTH-1:0]     a_d, q_d;

`ifdef BOOTH_OPCNT_EN
  logic [3:0]           opcnt_q, opcnt_d, op_count_q;
`endif

  eightbitaddsub u_alu (
    .data0_i     (a_q),
    .data1_i     (m_q),
    .mode_i      (alu_mode),
    .sum_o       (alu_sum),
    .carry_out_o (alu_cout_unused),
    .overflow_o  (alu_ovf)
  );

  // The shifted-in sign is the true 9-bit sign, so M = -128 stays correct.
  always_comb begin
    op       = booth_decode(q_q[0], q1_q);
    alu_mode = (op == OP_ADD) ? MODE_ADD : MODE_SUB;
    r        = (op == OP_NOP) ? a_q : alu_sum;
    sgn      = r[WIDTH-1] ^ ((op != OP_NOP) & alu_ovf);
    a_d      = {sgn, r[WIDTH-1:1]};
    q_d      = {r[0], q_q[WIDTH-1:1]};
`ifdef BOOTH_OPCNT_EN
    opcnt_d  = opcnt_q + ((op != OP_NOP) ? 4'd1 : 4'd0);
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      a_q        <= '0;
      q_q        <= '0;
      m_q        <= '0;
      q1_q       <= 1'b0;
      count_q    <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      product_q  <= '0;
`ifdef BOOTH_OPCNT_EN
      opcnt_q    <= '0;
      op_count_q <= '0;
`endif
    end else begin
      case (state_q)
        IDLE, DONE: begin
          done_q <= 1'b0;
          if (bus.start) begin
            a_q     <= '0;
            q_q     <= bus.multiplier;
            m_q     <= bus.multiplicand;
            q1_q    <= 1'b0;
            count_q <= '0;
            busy_q  <= 1'b1;
            state_q <= CALC;
`ifdef BOOTH_OPCNT_EN
            opcnt_q <= '0;
`endif
          end else begin
            state_q <= IDLE;
          end
        end
        CALC: begin
          a_q     <= a_d;
          q_q     <= q_d;
          q1_q    <= q_q[0];
          count_q <= count_q + 1'b1;
`ifdef BOOTH_OPCNT_EN
          opcnt_q <= opcnt_d;
`endif
          if (count_q == LAST) begin
            state_q    <= DONE;
            busy_q     <= 1'b0;
            done_q     <= 1'b1;
            product_q  <= {a_d, q_d};
`ifdef BOOTH_OPCNT_EN
            op_count_q <= opcnt_d;
`endif
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.product = product_q;
`ifdef BOOTH_OPCNT_EN
  assign bus.op_count = op_count_q;
`endif

endmodule
